// File: rtl/frame_cfg_pkg.sv
// frame_cfg_pkg: shared frame word defaults, frame word type and even-parity helper
package frame_cfg_pkg;
  localparam int FRAME_BITS = 32;
  localparam int ROW_SEL_W = 5;
  localparam int PARITY_MAX_BITS = 1024;
  typedef logic [FRAME_BITS-1:0] frame_word_t;
  function automatic logic even_parity(input logic [PARITY_MAX_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/frame_pipe_stage.sv
// frame_pipe_stage: one unconditionally clocked register stage for valid/row/data (+parity when FRAME_DATA_BANK_PARITY_EN)
module frame_pipe_stage
  import frame_cfg_pkg::*;
#(
  parameter int DataWidth = FRAME_BITS,
  parameter int RowWidth = ROW_SEL_W
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic                 src_valid,
  input  logic [RowWidth-1:0]  src_row,
  input  logic [DataWidth-1:0] src_data,
`ifdef FRAME_DATA_BANK_PARITY_EN
  input  logic                 src_par,
  output logic                 dst_par,
`endif
  output logic                 dst_valid,
  output logic [RowWidth-1:0]  dst_row,
  output logic [DataWidth-1:0] dst_data
);
  // register the stage; reset clears the valid bit so in-flight writes are discarded
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) begin
      dst_valid <= 1'b0;
      dst_row <= '0;
      dst_data <= '0;
    end else begin
      dst_valid <= src_valid;
      dst_row <= src_row;
      dst_data <= src_data;
    end
`ifdef FRAME_DATA_BANK_PARITY_EN
  // parity travels with its data word
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) dst_par <= 1'b0;
    else dst_par <= src_par;
`endif
endmodule

// File: rtl/frame_data_bank.sv
// frame_data_bank: multi-row frame data latch with input pipeline, strobes, write counter and clear; FRAME_DATA_BANK_PARITY_EN adds parity checking
module frame_data_bank
  import frame_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = FRAME_BITS,
  parameter int RowSelectWidth = ROW_SEL_W,
  parameter int RowBase = 1,
  parameter int NumRows = 4,
  parameter int InputStages = 1,
  parameter int CountWidth = 16
) (
  input  logic                               CLK,
  input  logic                               resetn,
  input  logic [FrameBitsPerRow-1:0]         FrameData_I,
  input  logic [RowSelectWidth-1:0]          RowSelect,
  input  logic                               FrameValid_I,
  input  logic                               Clear_I,
`ifdef FRAME_DATA_BANK_PARITY_EN
  input  logic                               FrameParity_I,
  output logic                               ParityErr_O,
`endif
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData_O,
  output logic [NumRows-1:0]                 FrameStrobe_O,
  output logic [CountWidth-1:0]              WriteCount_O,
  output logic                               Hit_O
);
  if (NumRows < 1 || NumRows > 16) begin : g_bad_rows
    $error("frame_data_bank: NumRows must be 1..16");
  end
  if (InputStages < 0 || InputStages > 3) begin : g_bad_stages
    $error("frame_data_bank: InputStages must be 0..3");
  end
  logic                       stage_valid [InputStages+1];
  logic [RowSelectWidth-1:0]  stage_row   [InputStages+1];
  logic [FrameBitsPerRow-1:0] stage_data  [InputStages+1];
  assign stage_valid[0] = FrameValid_I;
  assign stage_row[0] = RowSelect;
  assign stage_data[0] = FrameData_I;
`ifdef FRAME_DATA_BANK_PARITY_EN
  logic stage_par [InputStages+1];
  assign stage_par[0] = FrameParity_I;
`endif
  for (genvar s = 0; s < InputStages; s++) begin : g_stage
    frame_pipe_stage #(
      .DataWidth(FrameBitsPerRow),
      .RowWidth(RowSelectWidth)
    ) u_stage (
      .CLK(CLK),
      .resetn(resetn),
      .src_valid(stage_valid[s]),
      .src_row(stage_row[s]),
      .src_data(stage_data[s]),
`ifdef FRAME_DATA_BANK_PARITY_EN
      .src_par(stage_par[s]),
      .dst_par(stage_par[s+1]),
`endif
      .dst_valid(stage_valid[s+1]),
      .dst_row(stage_row[s+1]),
      .dst_data(stage_data[s+1])
    );
  end
  logic                       dec_valid;
  logic [RowSelectWidth-1:0]  dec_row;
  logic [FrameBitsPerRow-1:0] dec_data;
  logic                       in_range;
  logic                       parity_ok;
  logic                       write;
  logic [RowSelectWidth-1:0]  chan_idx;
  logic [NumRows-1:0]         sel;
  assign dec_valid = stage_valid[InputStages];
  assign dec_row = stage_row[InputStages];
  assign dec_data = stage_data[InputStages];
  assign in_range = int'(dec_row) >= RowBase && int'(dec_row) < RowBase + NumRows;
  assign chan_idx = dec_row - RowSelectWidth'(RowBase);
`ifdef FRAME_DATA_BANK_PARITY_EN
  assign parity_ok = even_parity(PARITY_MAX_BITS'(dec_data)) == stage_par[InputStages];
`else
  assign parity_ok = 1'b1;
`endif
  assign write = dec_valid && in_range && parity_ok && !Clear_I;
  for (genvar c = 0; c < NumRows; c++) begin : g_sel
    assign sel[c] = write && chan_idx == RowSelectWidth'(c);
  end
  // channel registers: clear wins, otherwise only the selected channel loads
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) FrameData_O <= '0;
    else if (Clear_I) FrameData_O <= '0;
    else
      for (int k = 0; k < NumRows; k++)
        if (sel[k]) FrameData_O[k*FrameBitsPerRow +: FrameBitsPerRow] <= dec_data;
  // one-cycle strobe per landed write; sel is already zero under clear
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) FrameStrobe_O <= '0;
    else FrameStrobe_O <= sel;
  // saturating count of landed writes
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) WriteCount_O <= '0;
    else if (write && !(&WriteCount_O)) WriteCount_O <= WriteCount_O + 1'b1;
  // hit flag tracks the address of the most recent decoded valid write
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) Hit_O <= 1'b0;
    else if (dec_valid) Hit_O <= in_range;
`ifdef FRAME_DATA_BANK_PARITY_EN
  // sticky parity error on an in-range write with bad parity
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) ParityErr_O <= 1'b0;
    else if (Clear_I) ParityErr_O <= 1'b0;
    else if (dec_valid && in_range && !parity_ok) ParityErr_O <= 1'b1;
`endif
endmodule

// File: tb/tb_frame_data_bank.sv
// tb_frame_data_bank: scoreboard bench for frame_data_bank (RowBase=1, NumRows=4, InputStages=1, CountWidth=4)
module tb_frame_data_bank;
  import frame_cfg_pkg::*;
  localparam int NR = 4;
  localparam int FB = 32;
  localparam int CW = 4;
  logic              CLK = 1'b0;
  logic              resetn = 1'b0;
  logic [FB-1:0]     FrameData_I = '0;
  logic [4:0]        RowSelect = '0;
  logic              FrameValid_I = 1'b0;
  logic              Clear_I = 1'b0;
  logic [NR*FB-1:0]  FrameData_O;
  logic [NR-1:0]     FrameStrobe_O;
  logic [CW-1:0]     WriteCount_O;
  logic              Hit_O;
  logic              ParityErr_O;
`ifdef FRAME_DATA_BANK_PARITY_EN
  logic              FrameParity_I = 1'b0;
`else
  assign ParityErr_O = 1'b0;
`endif
  int compared = 0;
  int mismatched = 0;

  frame_data_bank #(.CountWidth(CW)) dut (
    .CLK(CLK),
    .resetn(resetn),
    .FrameData_I(FrameData_I),
    .RowSelect(RowSelect),
    .FrameValid_I(FrameValid_I),
    .Clear_I(Clear_I),
`ifdef FRAME_DATA_BANK_PARITY_EN
    .FrameParity_I(FrameParity_I),
    .ParityErr_O(ParityErr_O),
`endif
    .FrameData_O(FrameData_O),
    .FrameStrobe_O(FrameStrobe_O),
    .WriteCount_O(WriteCount_O),
    .Hit_O(Hit_O)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NR*FB-1:0] chan;
    logic [NR-1:0]    strobe;
    logic [CW-1:0]    cnt;
    logic             hit;
    logic             perr;
  } exp_t;
  exp_t q[$];
  exp_t e;

  logic [NR*FB-1:0] m_chan;
  logic [NR-1:0]    m_strobe;
  logic [CW-1:0]    m_cnt;
  logic             m_hit, m_perr;
  logic             s_v, s_par;
  logic [4:0]       s_row;
  logic [FB-1:0]    s_data;

  task automatic model_reset();
    m_chan = '0; m_strobe = '0; m_cnt = '0; m_hit = 0; m_perr = 0;
    s_v = 0; s_par = 0; s_row = '0; s_data = '0;
  endtask

  task automatic model_step(input logic v, input logic [4:0] row, input logic [FB-1:0] data, input logic par, input logic clr);
    logic in, pok;
    in = s_v && s_row >= 5'd1 && s_row <= 5'd4;
`ifdef FRAME_DATA_BANK_PARITY_EN
    pok = ((^s_data) == s_par);
`else
    pok = 1'b1;
`endif
    m_strobe = '0;
    if (clr) begin
      m_chan = '0;
      m_perr = 0;
    end else if (in && pok) begin
      m_chan[(int'(s_row) - 1)*FB +: FB] = s_data;
      m_strobe[int'(s_row) - 1] = 1'b1;
      if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    end else if (in) m_perr = 1;
    if (s_v) m_hit = in;
    s_v = v; s_row = row; s_data = data; s_par = par;
  endtask

  task automatic step(input logic v, input logic [4:0] row, input logic [FB-1:0] data, input logic clr, input logic bad_par);
    exp_t x;
    logic par;
    par = (^data) ^ bad_par;
    @(negedge CLK);
    FrameValid_I = v; RowSelect = row; FrameData_I = data; Clear_I = clr;
`ifdef FRAME_DATA_BANK_PARITY_EN
    FrameParity_I = par;
`endif
    model_step(v, row, data, par, clr);
    x.chan = m_chan; x.strobe = m_strobe; x.cnt = m_cnt; x.hit = m_hit;
`ifdef FRAME_DATA_BANK_PARITY_EN
    x.perr = m_perr;
`else
    x.perr = 1'b0;
`endif
    q.push_back(x);
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'($urandom_range(0, 31)), $urandom, 1'b0, 1'b0);
  endtask

  // scoreboard: pop one expectation per clocked cycle and compare
  always @(posedge CLK) begin
    #1;
    if (resetn && q.size() > 0) begin
      e = q.pop_front();
      compared += 4;
      if (FrameData_O !== e.chan) begin mismatched++; $display("FAIL sb_data got %h want %h", FrameData_O, e.chan); end
      if (FrameStrobe_O !== e.strobe) begin mismatched++; $display("FAIL sb_strobe got %b want %b", FrameStrobe_O, e.strobe); end
      if (WriteCount_O !== e.cnt) begin mismatched++; $display("FAIL sb_count got %0d want %0d", WriteCount_O, e.cnt); end
      if (Hit_O !== e.hit) begin mismatched++; $display("FAIL sb_hit got %b want %b", Hit_O, e.hit); end
`ifdef FRAME_DATA_BANK_PARITY_EN
      compared++;
      if (ParityErr_O !== e.perr) begin mismatched++; $display("FAIL sb_perr got %b want %b", ParityErr_O, e.perr); end
`endif
    end
  end

  task automatic check_zero(input string name);
    compared++;
    if (FrameData_O !== '0 || FrameStrobe_O !== '0 || WriteCount_O !== '0 || Hit_O !== 1'b0 || ParityErr_O !== 1'b0) begin
      mismatched++;
      $display("FAIL %s got data=%h strobe=%b cnt=%0d hit=%b perr=%b want all zero", name, FrameData_O, FrameStrobe_O, WriteCount_O, Hit_O, ParityErr_O);
    end
  endtask

  task automatic test_reset();
    resetn = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset_state");
    @(negedge CLK);
    resetn = 1;
    idle(10);
    check_zero("idle_after_reset");
  endtask

  task automatic test_channel_write();
    step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0);
    compared++;
    if (FrameStrobe_O !== 4'b0000) begin mismatched++; $display("FAIL early_strobe got %b want 0000", FrameStrobe_O); end
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    compared += 3;
    if (FrameData_O !== {32'h0, 32'hDEADBEEF, 64'h0}) begin mismatched++; $display("FAIL chan2_data got %h want DEADBEEF in ch2", FrameData_O); end
    if (FrameStrobe_O !== 4'b0100) begin mismatched++; $display("FAIL chan2_strobe got %b want 0100", FrameStrobe_O); end
    if (WriteCount_O !== 4'd1) begin mismatched++; $display("FAIL chan2_count got %0d want 1", WriteCount_O); end
    idle(1);
    compared++;
    if (FrameStrobe_O !== 4'b0000) begin mismatched++; $display("FAIL strobe_single got %b want 0000", FrameStrobe_O); end
  endtask

  task automatic test_range();
    step(1'b1, 5'd0, 32'h11111111, 1'b0, 1'b0);
    step(1'b1, 5'd5, 32'h22222222, 1'b0, 1'b0);
    idle(1);
    compared += 3;
    if (Hit_O !== 1'b0) begin mismatched++; $display("FAIL range_hit got %b want 0", Hit_O); end
    if (WriteCount_O !== 4'd1) begin mismatched++; $display("FAIL range_count got %0d want 1", WriteCount_O); end
    if (FrameData_O[64 +: 32] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL range_hold got %h want DEADBEEF", FrameData_O[64 +: 32]); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 1'b0);
    step(1'b1, 5'd4, 32'h5A5A5A5A, 1'b0, 1'b0);
    compared++;
    if (FrameStrobe_O !== 4'b1000) begin mismatched++; $display("FAIL b2b_first got %b want 1000", FrameStrobe_O); end
    idle(1);
    compared += 2;
    if (FrameStrobe_O !== 4'b1000) begin mismatched++; $display("FAIL b2b_second got %b want 1000", FrameStrobe_O); end
    if (FrameData_O[96 +: 32] !== 32'h5A5A5A5A) begin mismatched++; $display("FAIL b2b_data got %h want 5A5A5A5A", FrameData_O[96 +: 32]); end
    idle(1);
  endtask

  task automatic test_clear();
    step(1'b1, 5'd1, 32'h12345678, 1'b0, 1'b0);
    step(1'b0, 5'd1, 32'h0, 1'b1, 1'b0);
    compared += 3;
    if (FrameData_O !== '0) begin mismatched++; $display("FAIL clear_data got %h want 0", FrameData_O); end
    if (FrameStrobe_O !== 4'b0000) begin mismatched++; $display("FAIL clear_strobe got %b want 0000", FrameStrobe_O); end
    if (WriteCount_O !== 4'd3) begin mismatched++; $display("FAIL clear_count got %0d want 3", WriteCount_O); end
    step(1'b1, 5'd2, 32'h55AA55AA, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    compared++;
    if (FrameData_O[32 +: 32] !== 32'h55AA55AA) begin mismatched++; $display("FAIL clear_inflight got %h want 55AA55AA", FrameData_O[32 +: 32]); end
    idle(1);
  endtask

  task automatic test_reset_midflight();
    step(1'b1, 5'd4, 32'hCAFEF00D, 1'b0, 1'b0);
    @(negedge CLK);
    FrameValid_I = 0;
    resetn = 0;
    model_reset();
    #1;
    check_zero("midflight_reset");
    @(negedge CLK);
    resetn = 1;
    idle(3);
    check_zero("midflight_no_strobe");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) step(1'b1, 5'd2, 32'hA0000000 + 32'(i), 1'b0, 1'b0);
    idle(1);
    compared += 2;
    if (WriteCount_O !== 4'd15) begin mismatched++; $display("FAIL sat_count got %0d want 15", WriteCount_O); end
    if (FrameData_O[32 +: 32] !== 32'hA0000013) begin mismatched++; $display("FAIL sat_data got %h want A0000013", FrameData_O[32 +: 32]); end
    idle(1);
  endtask

`ifdef FRAME_DATA_BANK_PARITY_EN
  task automatic test_parity();
    step(1'b1, 5'd1, 32'h00000001, 1'b0, 1'b1);
    idle(1);
    compared += 2;
    if (ParityErr_O !== 1'b1) begin mismatched++; $display("FAIL parity_err got %b want 1", ParityErr_O); end
    if (FrameData_O[0 +: 32] !== 32'h0) begin mismatched++; $display("FAIL parity_drop got %h want 0", FrameData_O[0 +: 32]); end
    step(1'b1, 5'd1, 32'h00000003, 1'b0, 1'b0);
    idle(1);
    compared += 2;
    if (FrameData_O[0 +: 32] !== 32'h3) begin mismatched++; $display("FAIL parity_good got %h want 3", FrameData_O[0 +: 32]); end
    if (ParityErr_O !== 1'b1) begin mismatched++; $display("FAIL parity_sticky got %b want 1", ParityErr_O); end
    idle(1);
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_channel_write();
    test_range();
    test_back_to_back();
    test_clear();
    test_reset_midflight();
    test_saturation();
`ifdef FRAME_DATA_BANK_PARITY_EN
    test_parity();
`endif
    repeat (3) @(posedge CLK);
    #2;
    compared++;
    if (q.size() != 0) begin mismatched++; $display("FAIL sb_drain got %0d pending want 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/frame_data_bank.md
Name: frame_data_bank

Overview:
- Multi-row successor to the single-row frame data latch in the configuration path.
- One instance serves NumRows consecutive fabric rows, starting at row index RowBase.
- Adds: a frame-valid qualifier, optional input pipeline stages for timing closure across long columns, per-row update strobes, a saturating accepted-write counter, and a synchronous clear.
- Sits between the frame address decoder and the tile columns of a fabric slice.

Parameters:
- FrameBitsPerRow, 32, width of one frame data word.
- RowSelectWidth, 5, width of the row select bus.
- RowBase, 1, row index served by channel 0.
- NumRows, 4, number of channels (1..16); channel k serves row RowBase+k.
- InputStages, 1, pipeline registers on FrameData_I/RowSelect/FrameValid_I before decode (0..3).
- CountWidth, 16, width of the accepted-write counter.

Ports:
- CLK  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- FrameData_I  input  FrameBitsPerRow  frame data word.
- RowSelect  input  RowSelectWidth  target row index.
- FrameValid_I  input  1  qualifies FrameData_I/RowSelect this cycle.
- Clear_I  input  1  synchronous clear of all channel registers.
- FrameData_O  output  NumRows*FrameBitsPerRow  channel k at bits [k*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe_O  output  NumRows  one-cycle pulse on bit k when channel k updated.
- WriteCount_O  output  CountWidth  saturating count of accepted writes.
- Hit_O  output  1  registered: last decoded valid write addressed this bank.

Behaviour:
- Reset (resetn low, asynchronous): all FrameData_O, FrameStrobe_O, WriteCount_O, Hit_O and all pipeline stage registers go to 0, including stage valid bits.
- Pipeline:
  - InputStages copies of {FrameValid_I, RowSelect, FrameData_I} in series, all unconditionally clocked.
  - InputStages=0 decodes the input directly.
- Decode at the last stage: accept when stage valid=1 and RowBase <= RowSelect < RowBase+NumRows. Channel index = RowSelect-RowBase, computed at RowSelectWidth bits with no wrap.
  - RowSelect out of range: no channel written, Hit_O=0, counter unchanged.
- Latency: accepted input at edge N appears on FrameData_O and FrameStrobe_O at edge N+InputStages+1.
  - Example: InputStages=0 gives a one-cycle latency.
- Strobes: FrameStrobe_O is one-hot or zero, asserted for exactly one cycle per accepted write.
  - Back-to-back writes to the same row give consecutive strobe pulses.
- Unselected channels hold their value.
- WriteCount_O increments by 1 per accepted write. It saturates at all-ones and does not wrap.
- Clear_I: on the next edge all channel registers become 0 and FrameStrobe_O becomes 0.
  - Clear_I does not affect pipeline stages or WriteCount_O.
  - Clear_I has priority over a simultaneous accepted write: the write is dropped and not counted.
  - Writes still in flight in the pipeline land after Clear_I deasserts.
- Reset asserted mid-pipeline discards in-flight writes. No strobe follows reset release until a new valid write propagates.
- FrameValid_I=0 performs no capture, whatever RowSelect and data carry.

Optional Feature:
- Macro: FRAME_DATA_BANK_PARITY_EN.
- Enabled:
  - Adds input FrameParity_I (1 bit, even parity of FrameData_I) and output ParityErr_O (1 bit).
  - FrameParity_I is pipelined alongside the data.
  - On an accepted write whose parity mismatches, the write is dropped: no channel update, no strobe, no count, and sticky ParityErr_O sets the following edge.
  - ParityErr_O is cleared only by resetn or Clear_I.
- Disabled: the ports do not exist and all writes are accepted per the decode rule.

Decomposition:
- Shared package frame_cfg_pkg:
  - default FrameBitsPerRow and RowSelectWidth constants;
  - a typedef for the frame word;
  - a function computing even parity.
- Sub-module frame_pipe_stage: one register stage carrying valid, row select, data and optional parity, with async reset. Instantiate it InputStages times in a generate loop.
- Decode, channel registers and counter stay in the top module.

Test Plan:
- Reset/idle: hold resetn=0 then release with FrameValid_I=0 for 10 cycles -> all outputs remain 0.
- Channel write (RowBase=1, NumRows=4, InputStages=1): valid write at RowSelect=3 with data 0xDEADBEEF.
  - Channel 2 equals 0xDEADBEEF two edges later.
  - FrameStrobe_O=4'b0100 for one cycle, WriteCount_O=1, other channels 0.
- Range check: writes at RowSelect=0 and RowSelect=5 -> no channel change, no strobe, Hit_O=0, count unchanged.
- Clear priority: Clear_I coincides with an accepted write of 0x12345678 to row 1 -> all channels 0, no strobe, count unchanged.
- Saturation: CountWidth=4, 20 back-to-back valid writes to row 2 -> WriteCount_O stops at 15 and channel 1 holds the last data word.
- Parity (macro on): write 0x00000001 with FrameParity_I=0 -> dropped and ParityErr_O=1 sticky; a following correct write updates normally and ParityErr_O stays 1.
